mcs4_clockgen: RTL and testbench

- Generates the MCS-4 two-phase non-overlapping bus clocks (clk1, clk2) and the power-on-clear (poc) from the FPGA sysclk.
- Sits directly upstream of every i4001/i4002/i4004 emulation and of timing_recovery, driving their clk1_pad, clk2_pad and poc_pad inputs.
- Defaults give a 1.35 us (~740 kHz) bus clock from a 20 MHz sysclk.

---
 rtl/mcs4_pkg.sv | 16 +
 rtl/mcs4_poc_gen.sv | 49 ++++
 rtl/mcs4_clockgen.sv | 135 +++++++++++++
 tb/tb_mcs4_clockgen.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcs4_pkg.sv
// Shared timing defaults and sequencer state encoding for the MCS-4 clock generator.
// Defaults: 27 ticks/period (1.35 us at 20 MHz), 64-period power-on-clear.
package mcs4_pkg;

  localparam int MCS4_PERIOD     = 27;
  localparam int MCS4_CLK1_W     = 8;
  localparam int MCS4_CLK2_START = 11;
  localparam int MCS4_CLK2_W     = 8;
  localparam int MCS4_POC_CYCLES = 64;

  typedef enum logic {
    PARKED  = 1'b0,
    RUNNING = 1'b1
  } mcs4_clk_state_t;

endpackage

// File: rtl/mcs4_poc_gen.sv
// Power-on-clear timer: counts bus periods while poc is high, then releases poc.
// Latency: poc falls one tick after the POC_CYCLES-th period_done; poc_req reloads next tick.
// No backpressure: free-running, poc_req always wins over a coincident period_done.
module mcs4_poc_gen
  import mcs4_pkg::*;
#(
  parameter int POC_CYCLES = MCS4_POC_CYCLES
) (
  input  logic sysclk,
  input  logic reset,
  input  logic period_done,
  input  logic poc_req,
  output logic poc
);

  localparam logic [9:0] POC_LAST = 10'(POC_CYCLES - 1);

  logic       poc_q;
  logic       poc_d;
  logic [9:0] poc_cnt_q;
  logic [9:0] poc_cnt_d;

  always_comb begin
    poc_d     = poc_q;
    poc_cnt_d = poc_cnt_q;
    if (poc_req) begin
      poc_d     = 1'b1;
      poc_cnt_d = '0;
    end else if (poc_q && period_done) begin
      poc_cnt_d = poc_cnt_q + 10'd1;
      if (poc_cnt_q == POC_LAST) begin
        poc_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      poc_q     <= 1'b1;
      poc_cnt_q <= '0;
    end else begin
      poc_q     <= poc_d;
      poc_cnt_q <= poc_cnt_d;
    end
  end

  assign poc = poc_q;

endmodule

// File: rtl/mcs4_clockgen.sv
// Two-phase non-overlapping MCS-4 bus clocks plus power-on-clear; MCS4_CLOCKGEN_STEP_EN adds single-period step.
// Latency: all outputs registered, decoded from the next counter value; clk1 rises on the first edge with run=1.
// No backpressure: dropping run parks only at the end of the current period, pulses are never truncated.
module mcs4_clockgen
  import mcs4_pkg::*;
#(
  parameter int PERIOD     = MCS4_PERIOD,
  parameter int CLK1_W     = MCS4_CLK1_W,
  parameter int CLK2_START = MCS4_CLK2_START,
  parameter int CLK2_W     = MCS4_CLK2_W,
  parameter int POC_CYCLES = MCS4_POC_CYCLES
) (
  input  logic sysclk,
  input  logic reset,
  input  logic run,
  input  logic poc_req,
`ifdef MCS4_CLOCKGEN_STEP_EN
  input  logic step,
`endif
  output logic clk1,
  output logic clk2,
  output logic poc,
  output logic period_done,
  output logic parked
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CLK1_END = CW'(CLK1_W);
  localparam logic [CW-1:0] CLK2_LO  = CW'(CLK2_START);
  localparam logic [CW-1:0] CLK2_HI  = CW'(CLK2_START + CLK2_W);

  // Timing rules that guarantee a low gap on both sides of every pulse.
  generate
    if (PERIOD < 4 || PERIOD > 255 || POC_CYCLES < 1 || POC_CYCLES > 1023 ||
        CLK1_W < 1 || CLK2_W < 1 || CLK1_W >= CLK2_START ||
        CLK2_START + CLK2_W >= PERIOD) begin : g_bad_cfg
      $error("mcs4_clockgen: illegal timing parameters");
    end
  endgenerate

  mcs4_clk_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            clk1_q, clk1_d;
  logic            clk2_q, clk2_d;
  logic            pd_q, pd_d;
  logic            start_go;

`ifdef MCS4_CLOCKGEN_STEP_EN
  logic step_q, step_d;

  always_comb begin
    step_d = step;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step_d;
    end
  end

  // Rising edge only, so a held step yields a single period.
  assign start_go = run | (step & ~step_q);
`else
  assign start_go = run;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      PARKED: begin
        cnt_d = CNT_LAST;
        if (start_go) begin
          state_d = RUNNING;
          cnt_d   = '0;
        end
      end
      RUNNING: begin
        if (cnt_q == CNT_LAST) begin
          if (run) begin
            cnt_d = '0;
          end else begin
            state_d = PARKED;
            cnt_d   = CNT_LAST;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = PARKED;
        cnt_d   = CNT_LAST;
      end
    endcase

    clk1_d = (state_d == RUNNING) && (cnt_d < CLK1_END);
    clk2_d = (state_d == RUNNING) && (cnt_d >= CLK2_LO) && (cnt_d < CLK2_HI);
    pd_d   = (state_d == RUNNING) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= PARKED;
      cnt_q   <= CNT_LAST;
      clk1_q  <= 1'b0;
      clk2_q  <= 1'b0;
      pd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk1_q  <= clk1_d;
      clk2_q  <= clk2_d;
      pd_q    <= pd_d;
    end
  end

  mcs4_poc_gen #(
    .POC_CYCLES (POC_CYCLES)
  ) u_poc_gen (
    .sysclk      (sysclk),
    .reset       (reset),
    .period_done (pd_q),
    .poc_req     (poc_req),
    .poc         (poc)
  );

  assign clk1        = clk1_q;
  assign clk2        = clk2_q;
  assign period_done = pd_q;
  assign parked      = (state_q == PARKED);

endmodule

// File: tb/tb_mcs4_clockgen.sv
// Bench for mcs4_clockgen: per-tick scoreboard of expected outputs plus directed timing checks.
module tb_mcs4_clockgen;

  localparam int P   = 27;
  localparam int C1W = 8;
  localparam int C2S = 11;
  localparam int C2W = 8;
  localparam int POC = 4;

  logic sysclk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic poc_req = 1'b0;
`ifdef MCS4_CLOCKGEN_STEP_EN
  logic step = 1'b0;
`endif
  logic clk1, clk2, poc, period_done, parked;

  always #5 sysclk = ~sysclk;

  mcs4_clockgen #(
    .PERIOD     (P),
    .CLK1_W     (C1W),
    .CLK2_START (C2S),
    .CLK2_W     (C2W),
    .POC_CYCLES (POC)
  ) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .run         (run),
    .poc_req     (poc_req),
`ifdef MCS4_CLOCKGEN_STEP_EN
    .step        (step),
`endif
    .clk1        (clk1),
    .clk2        (clk2),
    .poc         (poc),
    .period_done (period_done),
    .parked      (parked)
  );

  int n_vec = 0;
  int n_bad = 0;
  int tickno = 0;
  logic [4:0] exp_q[$];

  // Reference model state
  bit m_running = 1'b0;
  int m_cnt = P - 1;
  bit m_c1 = 1'b0, m_c2 = 1'b0, m_pd = 1'b0, m_poc = 1'b1;
  int m_pcnt = 0;
  bit m_step_prev = 1'b0;

  task automatic model_next();
    bit go;
    bit pd_old;
    pd_old = m_pd;
    if (reset) begin
      m_running = 1'b0; m_cnt = P - 1; m_c1 = 1'b0; m_c2 = 1'b0; m_pd = 1'b0;
      m_poc = 1'b1; m_pcnt = 0; m_step_prev = 1'b0;
    end else begin
      if (poc_req) begin
        m_poc = 1'b1; m_pcnt = 0;
      end else if (m_poc && pd_old) begin
        m_pcnt = m_pcnt + 1;
        if (m_pcnt == POC) m_poc = 1'b0;
      end
      go = run;
`ifdef MCS4_CLOCKGEN_STEP_EN
      go = run || (step && !m_step_prev);
      m_step_prev = step;
`endif
      if (!m_running) begin
        if (go) begin
          m_running = 1'b1; m_cnt = 0;
        end
      end else if (m_cnt == P - 1) begin
        if (run) m_cnt = 0;
        else m_running = 1'b0;
      end else begin
        m_cnt = m_cnt + 1;
      end
      m_c1 = m_running && (m_cnt < C1W);
      m_c2 = m_running && (m_cnt >= C2S) && (m_cnt < C2S + C2W);
      m_pd = m_running && (m_cnt == P - 1);
    end
    exp_q.push_back({m_c1, m_c2, m_pd, m_poc, !m_running});
  endtask

  task automatic tick();
    logic [4:0] e, a;
    model_next();
    @(posedge sysclk);
    #1;
    tickno++;
    e = exp_q.pop_front();
    a = {clk1, clk2, period_done, poc, parked};
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL scoreboard tick %0d: {clk1,clk2,pd,poc,parked} got %b want %b", tickno, a, e);
    end
    n_vec++;
    if ((clk1 & clk2) !== 1'b0) begin
      n_bad++;
      $display("FAIL overlap tick %0d: clk1=%b clk2=%b", tickno, clk1, clk2);
    end
  endtask

  task automatic do_reset(input bit r);
    reset = 1'b1; run = r; poc_req = 1'b0;
`ifdef MCS4_CLOCKGEN_STEP_EN
    step = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    tickno = 0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    n_vec++;
    if ({clk1, clk2, period_done, poc, parked} !== 5'b00011) begin
      n_bad++;
      $display("FAIL reset_state: got %b want 00011", {clk1, clk2, period_done, poc, parked});
    end
    for (int i = 0; i < 10; i++) tick();
    n_vec++;
    if (parked !== 1'b1 || clk1 !== 1'b0) begin
      n_bad++;
      $display("FAIL park_idle: parked=%b clk1=%b want 1 0", parked, clk1);
    end
  endtask

  task automatic test_clock_phases();
    int c1_first, c1_last, c2_first, c2_last, pd_first, pd_cnt;
    c1_first = -1; c1_last = -1; c2_first = -1; c2_last = -1; pd_first = -1; pd_cnt = 0;
    do_reset(1'b1);
    for (int i = 0; i < 3 * P; i++) begin
      tick();
      if (tickno <= P) begin
        if (clk1 && c1_first < 0) c1_first = tickno;
        if (clk1) c1_last = tickno;
        if (clk2 && c2_first < 0) c2_first = tickno;
        if (clk2) c2_last = tickno;
      end
      if (period_done) begin
        pd_cnt++;
        if (pd_first < 0) pd_first = tickno;
      end
    end
    n_vec++;
    if (c1_first != 1 || c1_last != 8) begin
      n_bad++;
      $display("FAIL clk1_window: got %0d..%0d want 1..8", c1_first, c1_last);
    end
    n_vec++;
    if (c2_first != 12 || c2_last != 19) begin
      n_bad++;
      $display("FAIL clk2_window: got %0d..%0d want 12..19", c2_first, c2_last);
    end
    n_vec++;
    if (pd_first != 27 || pd_cnt != 3) begin
      n_bad++;
      $display("FAIL period_done: first %0d count %0d want 27 3", pd_first, pd_cnt);
    end
  endtask

  task automatic test_poc_interval();
    int fall;
    bit hi108;
    fall = -1; hi108 = 1'b0;
    do_reset(1'b1);
    for (int i = 0; i < 130; i++) begin
      tick();
      if (tickno == 108) hi108 = poc;
      if (!poc && fall < 0) fall = tickno;
    end
    n_vec++;
    if (fall != 109 || hi108 !== 1'b1) begin
      n_bad++;
      $display("FAIL poc_interval: fall tick %0d poc@108=%b want 109 1", fall, hi108);
    end
  endtask

  task automatic test_poc_req();
    int fall;
    fall = -1;
    do_reset(1'b1);
    for (int i = 0; i < 200; i++) begin
      poc_req = (tickno == 54);
      tick();
      if (!poc && fall < 0) fall = tickno;
    end
    poc_req = 1'b0;
    n_vec++;
    if (fall != 163) begin
      n_bad++;
      $display("FAIL poc_req_reload: fall tick %0d want 163", fall);
    end
  endtask

  task automatic test_run_drop();
    int c1, c2, pd, park_at;
    c1 = 0; c2 = 0; pd = 0; park_at = -1;
    do_reset(1'b1);
    for (int i = 0; i < 40; i++) begin
      run = (tickno < 4);
      tick();
      c1 += int'(clk1);
      c2 += int'(clk2);
      pd += int'(period_done);
      if (parked && park_at < 0) park_at = tickno;
    end
    n_vec++;
    if (c1 != C1W || c2 != C2W || pd != 1) begin
      n_bad++;
      $display("FAIL run_drop_pulses: clk1 %0d clk2 %0d pd %0d want 8 8 1", c1, c2, pd);
    end
    n_vec++;
    if (park_at != 28) begin
      n_bad++;
      $display("FAIL run_drop_park: parked at %0d want 28", park_at);
    end
    run = 1'b1;
    tick();
    n_vec++;
    if (clk1 !== 1'b1 || parked !== 1'b0) begin
      n_bad++;
      $display("FAIL restart: clk1=%b parked=%b want 1 0", clk1, parked);
    end
  endtask

  task automatic test_reset_mid_clk2();
    do_reset(1'b1);
    while (tickno < 15) tick();
    n_vec++;
    if (clk2 !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_clk2: got %b want 1", clk2);
    end
    reset = 1'b1;
    tick();
    n_vec++;
    if ({clk1, clk2, poc, parked} !== 4'b0011) begin
      n_bad++;
      $display("FAIL mid_reset: {clk1,clk2,poc,parked} got %b want 0011", {clk1, clk2, poc, parked});
    end
    reset = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 5; i++) tick();
  endtask

`ifdef MCS4_CLOCKGEN_STEP_EN
  task automatic test_step();
    int r1, r2, pd;
    bit p1, p2;
    r1 = 0; r2 = 0; pd = 0; p1 = 1'b0; p2 = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) tick();
    step = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (clk1 && !p1) r1++;
      if (clk2 && !p2) r2++;
      pd += int'(period_done);
      p1 = clk1; p2 = clk2;
    end
    step = 1'b0;
    tick();
    n_vec++;
    if (r1 != 1 || r2 != 1 || pd != 1 || parked !== 1'b1) begin
      n_bad++;
      $display("FAIL step_one_period: clk1 %0d clk2 %0d pd %0d parked %b want 1 1 1 1", r1, r2, pd, parked);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clock_phases();
    test_poc_interval();
    test_poc_req();
    test_run_drop();
    test_reset_mid_clk2();
`ifdef MCS4_CLOCKGEN_STEP_EN
    test_step();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
